sop_vector_driver: RTL and testbench
====================================

// Module: sop_vector_driver
// PURPOSE
//  Synthesizable stimulus/response end of the sum-of-products test design.
//  - Generates pseudo-random 8x4-bit operand vectors from a 32-bit LFSR and drives them into a combinational SOP block.
//  - Samples that block's q_0/q_1 outputs and compresses them into a 16-bit MISR signature and two one-counts.
//  - Lets a run be checked in-circuit without an external bench.
// PARAMETERS
//  CNT_W          16            width of vector count and one-counters
//  SETTLE_CYCLES  1             cycles each vector is held before q is sampled (>=1)
//  LFSR_TAPS      32'h80200003  Galois right-shift tap mask (x^32+x^22+x^2+x+1)
//  MISR_POLY      16'h1021      MISR feedback polynomial
// PORTS
//  clk_i        in   1      clock, all state on rising edge
//  rst_n_i      in   1      reset, synchronous, active-low
//  start_i      in   1      begin a run; sampled only in IDLE
//  seed_i       in   32     LFSR seed, latched on accepted start
//  num_vec_i    in   CNT_W  vectors in run, latched on accepted start
//  q_0_i        in   1      SOP response bit 0
//  q_1_i        in   1      SOP response bit 1
//  data_0_o..data_7_o out 4 each  operand nibbles; data_k_o = lfsr[4k+3:4k]
//  busy_o       out  1      high in DRIVE/SAMPLE
//  done_o       out  1      one-cycle pulse at end of run
//  signature_o  out  16     MISR result, valid from done_o until next start
//  ones_0_o     out  CNT_W  count of samples with q_0_i=1
//  ones_1_o     out  CNT_W  count of samples with q_1_i=1
// BEHAVIOUR
//  Reset (rst_n_i=0 at edge): state=IDLE, lfsr=0, all data_k_o=0, busy_o=0, done_o=0, signature_o=0, ones_*=0, counters=0.
//  - Reset mid-run aborts immediately; no done_o is generated.
//  FSM states IDLE, DRIVE, SAMPLE, DONE:
//   IDLE: start_i=1 -> latch num_vec_i.
//    - num_vec_i=0: go to DONE; signature/ones cleared to 0.
//    - Otherwise: lfsr<=(seed_i==0 ? 32'h1 : seed_i); signature, ones and vec count cleared; go to DRIVE.
//   DRIVE: hold lfsr for SETTLE_CYCLES cycles (settle counter), then go to SAMPLE.
//   SAMPLE (1 cycle): capture q_*_i.
//    - sig <= {sig[14:0],1'b0} ^ (sig[15]?MISR_POLY:0) ^ {14'b0,q_1_i,q_0_i}.
//    - ones_k += q_k_i; vec count += 1.
//    - If count+1==num_vec: go to DONE, lfsr unchanged.
//    - Else: lfsr <= (lfsr>>1) ^ (lfsr[0]?LFSR_TAPS:0); go to DRIVE.
//   DONE (1 cycle): done_o=1, busy_o=0; go to IDLE. start_i in DONE is ignored.
//  - start_i while busy is ignored; seed_i/num_vec_i changes mid-run have no effect.
//  - Latency: vector n (0-based) appears on data_k_o at start+1+n*(SETTLE_CYCLES+1).
//  - done_o fires at start+1+N*(SETTLE_CYCLES+1).
//  - All outputs are registered; q_*_i may be purely combinational from data_k_o.
//  - data_k_o, signature_o and ones_* hold their values after DONE until the next accepted start.
//  - Counters cannot overflow: the vector count is bounded by num_vec_i, which is CNT_W wide.
// STRUCTURE
//  - Package sop_pkg: the state enum, the LFSR_TAPS/MISR_POLY defaults, and a NIBBLES=8 constant.
//  - One sub-module, sop_misr, holds the 16-bit signature register (clear, enable, 2-bit input).
//  - FSM, LFSR and counters stay in the top module.
// TESTING
//  1 Reset mid-run: assert rst_n_i in DRIVE -> next cycle all outputs 0, state IDLE, no done_o.
//  2 seed=32'h1, N=2, q tied 0 -> first vector data_0_o=1, others 0.
//    - Second vector: data_0_o=3, data_5_o=2, data_7_o=8, others 0.
//    - Final result: signature 0, ones 0/0.
//  3 seed=32'h0, N=1 -> seeds as 1, so data_0_o=1, others 0; done_o 3 cycles after start.
//  4 q_0_i=q_1_i=1, N=4, SETTLE=1 -> done_o exactly 9 cycles after start.
//    - signature_o=16'h0011, ones_0_o=ones_1_o=4.
//  5 num_vec_i=0 -> done_o the cycle after start; data unchanged; signature 0; busy_o never high.
//  6 Pulse start_i again during busy with different seed -> ignored; run completes with original seed/N values.
//  Additionally: connect the sop block and compare signature/ones against a reference model over N=10000.

Source files
------------

// File: rtl/sop_pkg.sv
// Shared definitions for the sum-of-products vector driver.
//  - state_t   : driver FSM states
//  - defaults  : LFSR tap mask, MISR polynomial, operand nibble count
//  - helpers   : one-step LFSR and MISR update functions
package sop_pkg;

    localparam logic [31:0] LFSR_TAPS_DEF = 32'h80200003;
    localparam logic [15:0] MISR_POLY_DEF = 16'h1021;
    localparam int          NIBBLES       = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Galois right-shift LFSR: the bit shifted out selects the tap mask.
    function automatic logic [31:0] lfsr_step(input logic [31:0] state,
                                              input logic [31:0] taps);
        lfsr_step = (state >> 1) ^ (state[0] ? taps : 32'h0000_0000);
    endfunction

    // MISR: shift left, fold the outgoing MSB through the polynomial, inject 2 bits.
    function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                              input logic [15:0] poly,
                                              input logic [1:0]  din);
        misr_step = {sig[14:0], 1'b0} ^ (sig[15] ? poly : 16'h0000) ^ {14'b0, din};
    endfunction

endpackage

// File: rtl/sop_misr.sv
// 16-bit multiple-input signature register with 2-bit input.
//  i_clk   : clock
//  i_rst_n : synchronous active-low reset (clears signature)
//  i_clr   : synchronous clear (start of run)
//  i_en    : compress i_din into the signature this cycle
//  i_din   : response bits {q_1, q_0}
//  o_sig   : current signature
module sop_misr
    import sop_pkg::*;
#(
    parameter logic [15:0] POLY = MISR_POLY_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [1:0]  i_din,
    output logic [15:0] o_sig
);

    logic [15:0] r_sig;

    // Signature register: clear wins over compress.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sig <= 16'h0000;
        end else if (i_clr) begin
            r_sig <= 16'h0000;
        end else if (i_en) begin
            r_sig <= misr_step(r_sig, POLY, i_din);
        end else begin
            r_sig <= r_sig;
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/sop_vector_driver.sv
// Stimulus/response end of the sum-of-products test design.
// Drives LFSR operand vectors, samples q_0/q_1 after a settle time and
// compresses them into a MISR signature plus two one-counts.
//  clk_i, rst_n_i          : clock, synchronous active-low reset
//  start_i, seed_i, num_vec_i : run request (accepted only in IDLE)
//  q_0_i, q_1_i            : SOP responses
//  data_0_o..data_7_o      : operand nibbles, data_k_o = lfsr[4k+3:4k]
//  busy_o, done_o          : run in progress / one-cycle end-of-run pulse
//  signature_o, ones_0_o, ones_1_o : run results, held until next start
module sop_vector_driver
    import sop_pkg::*;
#(
    parameter int          CNT_W         = 16,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [31:0] LFSR_TAPS     = LFSR_TAPS_DEF,
    parameter logic [15:0] MISR_POLY     = MISR_POLY_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [31:0]      seed_i,
    input  logic [CNT_W-1:0] num_vec_i,
    input  logic             q_0_i,
    input  logic             q_1_i,
    output logic [3:0]       data_0_o,
    output logic [3:0]       data_1_o,
    output logic [3:0]       data_2_o,
    output logic [3:0]       data_3_o,
    output logic [3:0]       data_4_o,
    output logic [3:0]       data_5_o,
    output logic [3:0]       data_6_o,
    output logic [3:0]       data_7_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [15:0]      signature_o,
    output logic [CNT_W-1:0] ones_0_o,
    output logic [CNT_W-1:0] ones_1_o
);

    localparam int LFSR_W   = NIBBLES * 4;
    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [LFSR_W-1:0]   r_lfsr;
    logic [CNT_W-1:0]    r_num_vec;
    logic [CNT_W-1:0]    r_vec_cnt;
    logic [SETTLE_W-1:0] r_settle;
    logic [CNT_W-1:0]    r_ones_0;
    logic [CNT_W-1:0]    r_ones_1;
    logic                r_busy;
    logic                r_done;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_accept;
    logic                w_settle_done;
    logic                w_last;
    logic                w_sample;
    logic [15:0]         w_sig;

    assign w_cnt_inc = r_vec_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state and control strobes.
    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_settle_done = 1'b0;
        w_last        = 1'b0;
        w_sample      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_accept = 1'b1;
                    if (num_vec_i == {CNT_W{1'b0}}) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_DRIVE;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (r_settle == SETTLE_LAST) begin
                    w_settle_done = 1'b1;
                    w_next_state  = ST_SAMPLE;
                end else begin
                    w_next_state  = ST_DRIVE;
                end
            end
            ST_SAMPLE: begin
                w_sample = 1'b1;
                if (w_cnt_inc == r_num_vec) begin
                    w_last       = 1'b1;
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_DRIVE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: LFSR, counters and registered status flags.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_lfsr    <= {LFSR_W{1'b0}};
            r_num_vec <= {CNT_W{1'b0}};
            r_vec_cnt <= {CNT_W{1'b0}};
            r_settle  <= {SETTLE_W{1'b0}};
            r_ones_0  <= {CNT_W{1'b0}};
            r_ones_1  <= {CNT_W{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // Flags track the state being entered so they line up with it.
            r_busy <= (w_next_state == ST_DRIVE) || (w_next_state == ST_SAMPLE);
            r_done <= (w_next_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_num_vec <= num_vec_i;
                        r_vec_cnt <= {CNT_W{1'b0}};
                        r_settle  <= {SETTLE_W{1'b0}};
                        r_ones_0  <= {CNT_W{1'b0}};
                        r_ones_1  <= {CNT_W{1'b0}};
                        // An empty run leaves the last vector on the outputs.
                        if (num_vec_i != {CNT_W{1'b0}}) begin
                            r_lfsr <= (seed_i == 32'h0000_0000) ? 32'h0000_0001 : seed_i;
                        end else begin
                            r_lfsr <= r_lfsr;
                        end
                    end else begin
                        r_num_vec <= r_num_vec;
                    end
                end
                ST_DRIVE: begin
                    if (w_settle_done) begin
                        r_settle <= {SETTLE_W{1'b0}};
                    end else begin
                        r_settle <= r_settle + {{(SETTLE_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_SAMPLE: begin
                    r_ones_0  <= r_ones_0 + {{(CNT_W-1){1'b0}}, q_0_i};
                    r_ones_1  <= r_ones_1 + {{(CNT_W-1){1'b0}}, q_1_i};
                    r_vec_cnt <= w_cnt_inc;
                    // The final vector stays on the outputs after the run.
                    if (!w_last) begin
                        r_lfsr <= lfsr_step(r_lfsr, LFSR_TAPS);
                    end else begin
                        r_lfsr <= r_lfsr;
                    end
                end
                default: begin
                    r_lfsr <= r_lfsr;
                end
            endcase
        end
    end

    sop_misr #(
        .POLY (MISR_POLY)
    ) u_misr (
        .i_clk   (clk_i),
        .i_rst_n (rst_n_i),
        .i_clr   (w_accept),
        .i_en    (w_sample),
        .i_din   ({q_1_i, q_0_i}),
        .o_sig   (w_sig)
    );

    assign data_0_o    = r_lfsr[3:0];
    assign data_1_o    = r_lfsr[7:4];
    assign data_2_o    = r_lfsr[11:8];
    assign data_3_o    = r_lfsr[15:12];
    assign data_4_o    = r_lfsr[19:16];
    assign data_5_o    = r_lfsr[23:20];
    assign data_6_o    = r_lfsr[27:24];
    assign data_7_o    = r_lfsr[31:28];
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign signature_o = w_sig;
    assign ones_0_o    = r_ones_0;
    assign ones_1_o    = r_ones_1;

endmodule

// File: tb/tb_sop_vector_driver.sv
// Bench for sop_vector_driver: directed table, hand sequences, random runs
// against a run-level reference model, with a small SOP block closing the loop.
module tb_sop_vector_driver;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [31:0]      seed;
    logic [CNT_W-1:0] num_vec;
    logic             q0, q1;
    logic [3:0]       d0, d1, d2, d3, d4, d5, d6, d7;
    logic             busy, done;
    logic [15:0]      sig;
    logic [CNT_W-1:0] ones0, ones1;
    logic [1:0]       q_mode;   // 0: q tied 0, 1: q tied 1, 2: SOP block
    logic [31:0]      w_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sop_vector_driver #(.CNT_W(CNT_W), .SETTLE_CYCLES(1)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .seed_i(seed),
        .num_vec_i(num_vec), .q_0_i(q0), .q_1_i(q1),
        .data_0_o(d0), .data_1_o(d1), .data_2_o(d2), .data_3_o(d3),
        .data_4_o(d4), .data_5_o(d5), .data_6_o(d6), .data_7_o(d7),
        .busy_o(busy), .done_o(done), .signature_o(sig),
        .ones_0_o(ones0), .ones_1_o(ones1)
    );

    assign w_data = {d7, d6, d5, d4, d3, d2, d1, d0};

    // Reference SOP block: s = d0*d1 + d2*d3 + d4*d5 + d6*d7.
    function automatic logic [1:0] sop(input logic [31:0] v);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            s = s + int'(v[8*k +: 4]) * int'(v[8*k+4 +: 4]);
        end
        return {s[5], s[0] ^ s[4]};
    endfunction

    function automatic logic [1:0] resp(input logic [1:0] mode, input logic [31:0] v);
        if (mode == 2'd0) return 2'b00;
        if (mode == 2'd1) return 2'b11;
        return sop(v);
    endfunction

    always_comb {q1, q0} = resp(q_mode, w_data);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Run-level model: vectors are successive polynomial steps from the seed,
    // the signature is the polynomial division of the response stream.
    task automatic model(input logic [31:0] s, input int n, input logic [1:0] mode,
                         input logic [31:0] prev, output logic [15:0] e_sig,
                         output int e_o0, output int e_o1, output logic [31:0] e_last);
        logic [31:0] x;
        logic [1:0]  q;
        e_sig = 16'h0000; e_o0 = 0; e_o1 = 0;
        if (n == 0) begin
            e_last = prev;
            return;
        end
        x = (s == 32'h0) ? 32'h1 : s;
        for (int v = 0; v < n; v++) begin
            q = resp(mode, x);
            e_sig = (e_sig << 1) ^ (e_sig[15] ? 16'h1021 : 16'h0000) ^ {14'b0, q};
            e_o0 += int'(q[0]);
            e_o1 += int'(q[1]);
            if (v != n - 1) x = (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
        end
        e_last = x;
    endtask

    // Start a run, wait (bounded) for done_o; lat=-1 on timeout.
    task automatic run(input logic [31:0] s, input int n, input logic [1:0] mode,
                       input bit pulse, output int lat, output logic busy_seen,
                       output logic [31:0] vec0, output logic [31:0] vec1);
        int limit;
        limit = 2 * n + 10;
        q_mode = mode;
        @(negedge clk);
        seed = s; num_vec = CNT_W'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0; seed = $urandom; num_vec = CNT_W'($urandom);
        lat = 1; busy_seen = busy; vec0 = w_data; vec1 = 32'h0;
        while (!done && lat < limit) begin
            @(negedge clk);
            lat++;
            busy_seen |= busy;
            if (lat == 3) vec1 = w_data;
            if (pulse && lat == 2) begin
                start = 1'b1; seed = ~s; num_vec = CNT_W'(1);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!done) lat = -1;
    endtask

    typedef struct {
        logic [31:0] seed;
        int          n;
        logic [1:0]  mode;
        int          lat;
        logic [15:0] sig;
        int          o0;
        int          o1;
        logic [31:0] data;
        logic        busy;
    } vec_t;

    vec_t        tbl[7];
    int          lat, e_o0, e_o1, n;
    logic        bs;
    logic [31:0] v0, v1, exp_data, e_last, s;
    logic [15:0] e_sig;

    task automatic check_run(input string tag, input int e_lat, input logic [15:0] es,
                             input int eo0, input int eo1, input logic [31:0] ed);
        chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
        chk({tag, "_sig"}, 32'(sig), 32'(es));
        chk({tag, "_ones0"}, 32'(ones0), 32'(eo0));
        chk({tag, "_ones1"}, 32'(ones1), 32'(eo1));
        chk({tag, "_data"}, w_data, ed);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'(0));
    endtask

    initial begin
        tbl[0] = '{32'h1,        2, 2'd0, 5,  16'h0000, 0, 0, 32'h80200003, 1'b1};
        tbl[1] = '{32'h0,        1, 2'd0, 3,  16'h0000, 0, 0, 32'h00000001, 1'b1};
        tbl[2] = '{32'h1,        4, 2'd1, 9,  16'h0011, 4, 4, 32'h60180001, 1'b1};
        tbl[3] = '{32'h5A5A5A5A, 0, 2'd1, 1,  16'h0000, 0, 0, 32'h60180001, 1'b0};
        tbl[4] = '{32'h1,        1, 2'd1, 3,  16'h0003, 1, 1, 32'h00000001, 1'b1};
        tbl[5] = '{32'h1,        2, 2'd1, 5,  16'h0005, 2, 2, 32'h80200003, 1'b1};
        tbl[6] = '{32'h1,        5, 2'd1, 11, 16'h0021, 5, 5, 32'hB02C0003, 1'b1};

        rst_n = 1'b0; start = 1'b0; seed = 32'h0; num_vec = '0; q_mode = 2'd0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {w_data ^ 32'(sig) ^ 32'(ones0) ^ 32'(ones1)}, 32'h0);
        chk("reset_flags", {30'b0, busy, done}, 32'h0);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            run(tbl[i].seed, tbl[i].n, tbl[i].mode, 1'b0, lat, bs, v0, v1);
            if (i == 0) begin
                chk("t2_vec0", v0, 32'h00000001);
                chk("t2_vec1", v1, 32'h80200003);
            end
            if (i == 1) chk("t3_vec0", v0, 32'h00000001);
            chk($sformatf("tbl%0d_busy", i), 32'(bs), 32'(tbl[i].busy));
            check_run($sformatf("tbl%0d", i), tbl[i].lat, tbl[i].sig,
                      tbl[i].o0, tbl[i].o1, tbl[i].data);
        end
        exp_data = w_data;

        // Start pulse during busy with different seed must be ignored.
        run(32'hDEADBEEF, 3, 2'd2, 1'b1, lat, bs, v0, v1);
        model(32'hDEADBEEF, 3, 2'd2, exp_data, e_sig, e_o0, e_o1, e_last);
        check_run("busy_start", 7, e_sig, e_o0, e_o1, e_last);
        exp_data = e_last;

        // Random short runs with the SOP block in the loop.
        for (int r = 0; r < 8; r++) begin
            s = $urandom;
            n = int'($urandom_range(0, 40));
            run(s, n, 2'd2, (r % 3) == 0 && n > 2, lat, bs, v0, v1);
            model(s, n, 2'd2, exp_data, e_sig, e_o0, e_o1, e_last);
            check_run($sformatf("rand%0d", r), 1 + 2 * n, e_sig, e_o0, e_o1, e_last);
            exp_data = e_last;
        end

        // Long run.
        s = $urandom;
        run(s, 10000, 2'd2, 1'b0, lat, bs, v0, v1);
        model(s, 10000, 2'd2, exp_data, e_sig, e_o0, e_o1, e_last);
        check_run("long", 20001, e_sig, e_o0, e_o1, e_last);

        // Reset mid-run: abort in DRIVE, everything clears, no done.
        q_mode = 2'd1;
        @(negedge clk);
        seed = 32'h1; num_vec = CNT_W'(5); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("midrst_in_drive", 32'(busy), 32'(1));
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_outputs", {w_data ^ 32'(sig) ^ 32'(ones0) ^ 32'(ones1)}, 32'h0);
        chk("midrst_flags", {30'b0, busy, done}, 32'h0);
        rst_n = 1'b1;
        bs = 1'b0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            bs |= done | busy;
        end
        chk("midrst_no_done", 32'(bs), 32'(0));

        // Recovery after reset.
        run(32'h1, 1, 2'd1, 1'b0, lat, bs, v0, v1);
        check_run("after_rst", 3, 16'h0003, 1, 1, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
